issue_bundle_reg: RTL and testbench
===================================

Name: issue_bundle_reg

Overview:
- Parametrised ID→EX issue-bundle pipeline register for an N-wide in-order issue core.
- Holds one bundle of LANES instruction slots between decode and execute.
- Uses a valid/ready handshake with per-lane kill (branch/delay-slot squash) and in-order prefix enforcement.
- Also provides full flush, an optional data-clearing mode, and saturating stall/bubble performance counters.

Parameters:
- LANES, 2, number of issue slots per bundle; lane 0 is oldest.
- DATA_W, 160, payload width per lane (decoded control + operands + pc).
- CNT_W, 32, width of each performance counter.
- CLEAR_DATA, 1, 1 = payload of invalid/dropped lanes is forced to 0; 0 = payload holds its previous value (power mode).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush (exception/eret); empties register, suppresses acceptance.
- in_valid  in  LANES  per-lane valid of decode bundle.
- in_data  in  LANES*DATA_W  lane i payload at [i*DATA_W +: DATA_W].
- in_ready  out  1  register can accept a bundle this cycle.
- kill_mask  in  LANES  lanes of the incoming bundle to drop on acceptance (EX branch resolution).
- out_valid  out  LANES  per-lane valid of the held bundle.
- out_data  out  LANES*DATA_W  held payload.
- out_ready  in  1  execute stage consumes the held bundle this cycle.
- out_new  out  1  high exactly in the first cycle a newly loaded, non-empty bundle is presented.
- clear_cnt  in  1  synchronous clear of both counters.
- stall_cnt  out  CNT_W  cycles with |out_valid && !out_ready.
- bubble_cnt  out  CNT_W  cycles with out_valid==0 && out_ready && !flush.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (reset).
- Reset values: out_valid=0, out_data=0, out_new=0, stall_cnt=0, bubble_cnt=0.
- in_ready (combinational) = out_ready || (out_valid==0). It is independent of in_valid and flush.
- accept = |in_valid && in_ready && !flush.
- retained mask r: r[0] = in_valid[0] & ~kill_mask[0]; r[i] = r[i-1] & in_valid[i] & ~kill_mask[i].
  - A lane is retained only if all older lanes are retained.
  - A valid lane behind a killed or invalid lane is dropped.
- Update priority per cycle (highest first):
  - reset → clear all.
  - flush → out_valid<=0; out_data<=0 if CLEAR_DATA, else hold; out_new<=0.
  - accept → out_valid<=r; for each lane, out_data lane <= in_data lane if r[i], else (0 if CLEAR_DATA else in_data lane); out_new<=(r!=0).
  - drain (out_ready && out_valid!=0, no accept) → out_valid<=0; out_data<=0 if CLEAR_DATA, else hold; out_new<=0.
  - otherwise hold; out_new<=0.
- Latency: one cycle from accept to out_valid.
- Throughput: one bundle per cycle when out_ready is held high.
- Stall (out_valid!=0, out_ready=0): in_ready=0 and the bundle plus out_valid are held unchanged. out_new is low after its first cycle.
- Accept with r==0 (all lanes killed): register becomes empty and out_new=0. Counts as consumed for the upstream handshake.
- Simultaneous flush and out_ready: flush wins; the held bundle is discarded and nothing is accepted.
- Counters:
  - Saturate at all-ones with no wrap.
  - clear_cnt has priority over increment.
  - Reset zeroes them.
  - They are not affected by flush.
- Reset asserted mid-stall clears the bundle in the same edge. in_ready is high the cycle after reset deasserts.
- No X propagation: out_data of invalid lanes is defined per CLEAR_DATA.

Test Plan (LANES=2, DATA_W=8, CNT_W=4 unless noted):
- Pass-through: in_valid=11, in_data={8'hB2,8'hA1}, out_ready=1 → next cycle out_valid=11, out_data={B2,A1}, out_new=1. Following cycle with in_valid=00 → out_valid=00, out_data=0, bubble_cnt increments by 1.
- Stall hold: load bundle, then out_ready=0 for 3 cycles while in_valid=11 with new data → in_ready=0, out_data unchanged, out_new high only in the first cycle, stall_cnt=3. Then out_ready=1 → the new bundle loads next cycle.
- Kill/prefix: in_valid=11, kill_mask=01 → out_valid=00, out_new=0. in_valid=10 with kill_mask=00 → out_valid=00. in_valid=11 with kill_mask=10 → out_valid=01, lane1 data=0 (CLEAR_DATA=1), or lane1 data = incoming value (CLEAR_DATA=0).
- Flush priority: bundle held, out_ready=1, flush=1, in_valid=11 → next cycle out_valid=00, out_data=0, nothing accepted. The cycle after, the bundle still on the input is accepted.
- Counter saturation/clear: force 20 stall cycles → stall_cnt=4'hF. clear_cnt=1 together with a stall cycle → stall_cnt=0.
- Reset mid-operation: bundle stalled, reset=1 for one cycle → all outputs 0 next cycle, in_ready=1. LANES=4 run: in_valid=1111, kill_mask=0100 → out_valid=0011.

Source files
------------

// File: rtl/issue_bundle_reg.sv
// ID->EX issue-bundle pipeline register: valid/ready handshake, per-lane kill with
// in-order prefix retention, flush, optional payload clearing and saturating perf counters.

module issue_bundle_lane #(
    parameter int DATA_W     = 160,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              accept,
    input  logic              drain,
    input  logic              keep,
    input  logic [DATA_W-1:0] din,
    output logic              valid,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            if (CLEAR_DATA != 0) data <= '0;
        end else if (accept) begin
            valid <= keep;
            // dropped lanes still latch the incoming payload in power mode to avoid a hold mux
            data  <= (keep || CLEAR_DATA == 0) ? din : '0;
        end else if (drain) begin
            valid <= 1'b0;
            if (CLEAR_DATA != 0) data <= '0;
        end
    end
endmodule

module issue_bundle_reg #(
    parameter int LANES      = 2,
    parameter int DATA_W     = 160,
    parameter int CNT_W      = 32,
    parameter int CLEAR_DATA = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    in_ready,
    input  logic [LANES-1:0]        kill_mask,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    out_ready,
    output logic                    out_new,
    input  logic                    clear_cnt,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
);
    logic             any_valid;
    logic             accept;
    logic             drain;
    logic [LANES-1:0] keep;

    assign any_valid = |out_valid;
    assign in_ready  = out_ready || !any_valid;
    assign accept    = (|in_valid) && in_ready && !flush;
    assign drain     = out_ready && any_valid && !accept;

    // a lane survives only if every older lane survived
    always_comb begin
        logic run;
        run  = 1'b1;
        keep = '0;
        for (int i = 0; i < LANES; i++) begin
            run     = run & in_valid[i] & ~kill_mask[i];
            keep[i] = run;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        issue_bundle_lane #(
            .DATA_W    (DATA_W),
            .CLEAR_DATA(CLEAR_DATA)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .accept(accept),
            .drain (drain),
            .keep  (keep[g]),
            .din   (in_data[g*DATA_W +: DATA_W]),
            .valid (out_valid[g]),
            .data  (out_data[g*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || flush) out_new <= 1'b0;
        else if (accept)    out_new <= |keep;
        else                out_new <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset || clear_cnt) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (any_valid && !out_ready && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!any_valid && out_ready && !flush && !(&bubble_cnt))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_issue_bundle_reg.sv
// Directed bench for issue_bundle_reg: 2-lane clearing instance plus a 4-lane power-mode instance.
module tb_issue_bundle_reg;
    logic        clk = 1'b0;
    logic        reset, flush, clear_cnt, out_ready, in_ready, out_new;
    logic [1:0]  in_valid, kill_mask, out_valid;
    logic [15:0] in_data, out_data;
    logic [3:0]  stall_cnt, bubble_cnt;

    logic        flush4, clear4, ordy4, irdy4, new4;
    logic [3:0]  iv4, km4, ov4, sc4, bc4;
    logic [31:0] id4, od4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  v;
        logic [15:0] d;
        logic        nw;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    issue_bundle_reg #(.LANES(2), .DATA_W(8), .CNT_W(4), .CLEAR_DATA(1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .kill_mask(kill_mask), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .out_new(out_new), .clear_cnt(clear_cnt),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    issue_bundle_reg #(.LANES(4), .DATA_W(8), .CNT_W(4), .CLEAR_DATA(0)) dut4 (
        .clk(clk), .reset(reset), .flush(flush4), .in_valid(iv4), .in_data(id4),
        .in_ready(irdy4), .kill_mask(km4), .out_valid(ov4), .out_data(od4),
        .out_ready(ordy4), .out_new(new4), .clear_cnt(clear4),
        .stall_cnt(sc4), .bubble_cnt(bc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // drive one cycle of stimulus, queue its expected result, then compare after the edge
    task automatic cyc(input string tag, input logic [1:0] iv, input logic [15:0] id,
                       input logic [1:0] km, input logic ordy, input logic fl, input logic clr,
                       input logic rst, input logic [1:0] ev, input logic [15:0] ed, input logic en);
        exp_t e;
        in_valid = iv; in_data = id; kill_mask = km; out_ready = ordy;
        flush = fl; clear_cnt = clr; reset = rst;
        exp_q.push_back('{v: ev, d: ed, nw: en});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk({tag, "_valid"}, 32'(out_valid), 32'(e.v));
        chk({tag, "_data"},  32'(out_data),  32'(e.d));
        chk({tag, "_new"},   32'(out_new),   32'(e.nw));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; clear_cnt = 1'b0; out_ready = 1'b0;
        in_valid = '0; in_data = '0; kill_mask = '0;
        flush4 = 1'b0; clear4 = 1'b0; ordy4 = 1'b0; iv4 = '0; km4 = '0; id4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_new", 32'(out_new), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_bubble", 32'(bubble_cnt), 0);
        reset = 1'b0; #1;
        chk("rst_inready", 32'(in_ready), 1);

        // pass-through then drain then bubble
        cyc("pass",   2'b11, 16'hB2A1, 2'b00, 1, 0, 1, 0, 2'b11, 16'hB2A1, 1);
        cyc("drain",  2'b00, 16'h0000, 2'b00, 1, 0, 0, 0, 2'b00, 16'h0000, 0);
        cyc("bubble", 2'b00, 16'h0000, 2'b00, 1, 0, 0, 0, 2'b00, 16'h0000, 0);
        chk("bubble_cnt1", 32'(bubble_cnt), 1);
        chk("stall_cnt0", 32'(stall_cnt), 0);

        // stall hold
        cyc("load", 2'b11, 16'hD4C3, 2'b00, 1, 0, 0, 0, 2'b11, 16'hD4C3, 1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 2'b11; out_ready = 1'b0; #1;
            chk("stall_inready", 32'(in_ready), 0);
            cyc("stall", 2'b11, 16'hF6E5, 2'b00, 0, 0, 0, 0, 2'b11, 16'hD4C3, 0);
        end
        chk("stall_cnt3", 32'(stall_cnt), 3);
        chk("bubble_cnt2", 32'(bubble_cnt), 2);
        cyc("unstall", 2'b11, 16'hF6E5, 2'b00, 1, 0, 0, 0, 2'b11, 16'hF6E5, 1);

        // kill / prefix
        cyc("kill0",  2'b11, 16'h1234, 2'b01, 1, 0, 0, 0, 2'b00, 16'h0000, 0);
        cyc("hole0",  2'b10, 16'h5678, 2'b00, 1, 0, 0, 0, 2'b00, 16'h0000, 0);
        cyc("kill1",  2'b11, 16'h9ABC, 2'b10, 1, 0, 0, 0, 2'b01, 16'h00BC, 1);

        // flush beats drain and accept; the waiting bundle goes in next cycle
        cyc("flush",  2'b11, 16'hDE77, 2'b00, 1, 1, 0, 0, 2'b00, 16'h0000, 0);
        cyc("postfl", 2'b11, 16'hDE77, 2'b00, 1, 0, 0, 0, 2'b11, 16'hDE77, 1);
        chk("bubble_cnt5", 32'(bubble_cnt), 5);

        // counter saturation and clear priority
        for (int i = 0; i < 20; i++)
            cyc("sat", 2'b00, 16'h0000, 2'b00, 0, 0, 0, 0, 2'b11, 16'hDE77, 0);
        chk("stall_sat", 32'(stall_cnt), 15);
        cyc("clr", 2'b00, 16'h0000, 2'b00, 0, 0, 1, 0, 2'b11, 16'hDE77, 0);
        chk("stall_clr", 32'(stall_cnt), 0);
        chk("bubble_clr", 32'(bubble_cnt), 0);

        // reset while stalled
        cyc("midrst", 2'b11, 16'h4321, 2'b00, 0, 0, 0, 1, 2'b00, 16'h0000, 0);
        reset = 1'b0; #1;
        chk("midrst_inready", 32'(in_ready), 1);
        chk("midrst_stall", 32'(stall_cnt), 0);

        // 4-lane power-mode instance: killed lane 2 cuts off lane 3, payload still latched
        iv4 = 4'b1111; km4 = 4'b0100; id4 = 32'h44332211; ordy4 = 1'b1;
        @(posedge clk); #1;
        chk("l4_valid", 32'(ov4), 32'h3);
        chk("l4_data", od4, 32'h44332211);
        chk("l4_new", 32'(new4), 1);
        iv4 = 4'b0000; id4 = 32'hAAAAAAAA;
        @(posedge clk); #1;
        chk("l4_drain_valid", 32'(ov4), 0);
        chk("l4_drain_hold", od4, 32'h44332211);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
